uart_hex_sender: RTL and testbench
==================================

UART_HEX_SENDER -- requirements
Module: uart_hex_sender

Interface
REQ-001 The block SHALL have parameter C_UART_DATA_WIDTH, default 8: UART word width; must be 8.
REQ-002 The block SHALL have parameter C_SAMPLE_WIDTH, default 16: sample width; a multiple of 4, range 4..32.
REQ-003 The block SHALL have parameter C_EOL, default 2: line terminator; 0 = none, 1 = LF, 2 = CR+LF.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rstb, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: permits new sample capture.
REQ-007 The block SHALL have port smpData, input, C_SAMPLE_WIDTH bits: sample word from the upstream producer.
REQ-008 The block SHALL have port smpValid, input, 1 bit: sample present; held by the producer until acknowledged.
REQ-009 The block SHALL have port smpAck, output, 1 bit: sample captured; 4-phase level.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 The block SHALL have port error, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-012 The block SHALL have port txBusy, input, 1 bit: UART_Tx busy flag.
REQ-013 The block SHALL have port txSend, output, 1 bit: UART_Tx send trigger.
REQ-014 The block SHALL have port txData, output, C_UART_DATA_WIDTH bits: byte to UART_Tx.
REQ-015 The block SHALL have port txErr, input, 1 bit: UART_Tx error flag.

Function
REQ-016 Frame format SHALL be N = C_SAMPLE_WIDTH/4 uppercase hex digits, MSB nibble first, followed by the terminator bytes (CR = 0x0D, LF = 0x0A).
REQ-017 Nibble encoding SHALL be: 0..9 -> 0x30+n; 10..15 -> 0x41+(n-10).
REQ-018 The FSM SHALL have states S_IDLE, S_SEND, S_WAIT.
REQ-019 In S_IDLE, enable=1, smpValid=1 and smpAck=0 SHALL latch smpData, set smpAck=1, busy=1, byte index=0, and go to S_SEND on the next edge.
REQ-020 smpAck SHALL remain high until smpValid is sampled low, then clear on the next edge, independently of FSM state.
REQ-021 In S_SEND, txSend SHALL be 1 and txData SHALL equal byte[index]; txBusy=1 SHALL clear txSend and go to S_WAIT.
REQ-022 In S_WAIT, txBusy=0 SHALL either advance the index and go to S_SEND, or, if the index is the last byte, clear busy and go to S_IDLE.
REQ-023 txData SHALL be stable while txSend=1.
REQ-024 Latency SHALL be: txSend asserted on the second edge after smpValid is sampled high in S_IDLE.
REQ-025 txErr=1 in S_SEND or S_WAIT SHALL drive txSend=0 and error=1 for one cycle, clear busy, and go to S_IDLE; the rest of the frame is discarded.
REQ-026 enable falling mid-frame SHALL let the current frame complete; no new capture until enable=1.
REQ-027 smpValid arriving while busy=1 SHALL be left unacknowledged until return to S_IDLE; no sample is lost or overwritten.
REQ-028 A byte counter wraps only via return to S_IDLE, never past N + terminator count minus one.

Reset
REQ-029 rstb=0 SHALL asynchronously force S_IDLE, smpAck=0, busy=0, error=0, txSend=0, txData=0, index=0, sample register=0.
REQ-030 Reset mid-frame SHALL drop txSend immediately; after release, the block waits in S_IDLE for a fresh smpValid.

Structure
REQ-031 State enum, CR/LF constants and the nibble-to-ASCII function SHALL live in shared package sdad_uart_pkg.
REQ-032 The design SHALL have no sub-module; one FSM plus a byte mux selecting digit or terminator by index.

Verification
REQ-033 smpData=0x1A3F, C_EOL=2 -> txData sequence 0x31,0x41,0x33,0x46,0x0D,0x0A; one smpAck; busy low after the last byte.
REQ-034 smpData=0x0000, then 0xFFFF, back-to-back with C_EOL=0 -> "0000" then "FFFF"; second smpAck only after the first frame ends.
REQ-035 txErr pulsed during the third byte of 0xBEEF -> bytes 0x42,0x45 only, error pulse of exactly 1 cycle, return to S_IDLE, next sample sent whole.
REQ-036 rstb low during the second byte -> txSend=0 immediately, all outputs at reset values; next sample 0x1234 sends "1234\r\n".
REQ-037 enable=0 with smpValid=1 -> smpAck stays 0 for 100 cycles; enable=1 -> capture within 1 cycle.
REQ-038 Closed loop with UART_Tx/UART_Rx at 921600 baud, 100 MHz -> Rx bytes match the expected ASCII for 50 random samples.

Source files
------------

// File: rtl/sdad_uart_pkg.sv
// Shared definitions for the UART hex sender: FSM states, line terminator bytes
// and the nibble-to-ASCII encoder.
package sdad_uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h41 + ({4'h0, n} - 8'd10);
  endfunction

endpackage

// File: rtl/uart_hex_sender.sv
// Captures a sample word over a 4-phase handshake and streams it to a UART
// transmitter as uppercase hex digits followed by an optional CR/LF terminator.
module uart_hex_sender
  import sdad_uart_pkg::*;
#(
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_SAMPLE_WIDTH    = 16,
  parameter int C_EOL             = 2
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         enable,
  input  logic [C_SAMPLE_WIDTH-1:0]    smpData,
  input  logic                         smpValid,
  output logic                         smpAck,
  output logic                         busy,
  output logic                         error,
  input  logic                         txBusy,
  output logic                         txSend,
  output logic [C_UART_DATA_WIDTH-1:0] txData,
  input  logic                         txErr
);

  localparam int N_DIGITS = C_SAMPLE_WIDTH / 4;
  localparam int N_EOL    = (C_EOL == 2) ? 2 : ((C_EOL == 1) ? 1 : 0);
  localparam int N_BYTES  = N_DIGITS + N_EOL;
  localparam int IDX_W    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  state_t                        state;
  state_t                        state_next;
  logic [IDX_W-1:0]              idx;
  logic [IDX_W-1:0]              idx_next;
  logic [C_SAMPLE_WIDTH-1:0]     sample;
  logic [C_SAMPLE_WIDTH-1:0]     sample_next;
  logic [C_SAMPLE_WIDTH-1:0]     shifted;
  logic [7:0]                    cur_byte;
  logic                          capture;
  logic                          send_next;
  logic                          error_next;
  logic                          busy_next;
  logic                          ack_next;
  logic [C_UART_DATA_WIDTH-1:0]  data_next;

  assign capture = (state == S_IDLE) && enable && smpValid && !smpAck;

  // Byte mux: digits first (MSB nibble at index 0), then the terminator bytes.
  always_comb begin
    cur_byte = 8'h00;
    shifted  = '0;
    if (int'(idx) < N_DIGITS) begin
      shifted  = sample >> (4 * (N_DIGITS - 1 - int'(idx)));
      cur_byte = nibble_to_ascii(shifted[3:0]);
    end else if (C_EOL == 2 && int'(idx) == N_DIGITS) begin
      cur_byte = CR;
    end else begin
      cur_byte = LF;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // A byte only counts as taken once txBusy rises while our own txSend is up,
  // so a busy flag left over from a previous byte cannot skip one.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (capture) state_next = S_SEND;
      S_SEND: begin
        if (txErr)
          state_next = S_IDLE;
        else if (txSend && txBusy)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (txErr)
          state_next = S_IDLE;
        else if (!txBusy)
          state_next = (idx == LAST_IDX) ? S_IDLE : S_SEND;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    send_next   = (state == S_SEND) && !txErr && !txBusy;
    error_next  = (state != S_IDLE) && txErr;
    busy_next   = (state_next != S_IDLE);
    data_next   = send_next ? C_UART_DATA_WIDTH'(cur_byte) : txData;
    sample_next = capture ? smpData : sample;
    idx_next    = idx;
    if (capture)
      idx_next = '0;
    else if (state == S_WAIT && !txBusy && !txErr && idx != LAST_IDX)
      idx_next = idx + 1'b1;
    ack_next = smpAck;
    if (capture)
      ack_next = 1'b1;
    else if (smpAck && !smpValid)
      ack_next = 1'b0;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      smpAck <= 1'b0;
      busy   <= 1'b0;
      error  <= 1'b0;
      txSend <= 1'b0;
      txData <= '0;
      idx    <= '0;
      sample <= '0;
    end else begin
      smpAck <= ack_next;
      busy   <= busy_next;
      error  <= error_next;
      txSend <= send_next;
      txData <= data_next;
      idx    <= idx_next;
      sample <= sample_next;
    end
  end

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed and randomized bench for uart_hex_sender with a behavioural UART
// transmitter responder and a string-based model of the expected output line.
module tb_uart_hex_sender;

  logic        clk;
  logic        rstb;
  logic        enable;
  logic [15:0] smpData;
  logic        smpValid;
  logic        smpAck;
  logic        busy;
  logic        error;
  logic        txBusy;
  logic        txSend;
  logic [7:0]  txData;
  logic        txErr;

  int testCount = 0;
  int failCount = 0;

  logic [7:0] rxQ[$];
  int         latency   = 3;
  int         cnt       = 0;
  int         sentCount = 0;
  int         errAt     = 0;
  bit         errArm    = 0;

  uart_hex_sender #(
    .C_UART_DATA_WIDTH(8),
    .C_SAMPLE_WIDTH(16),
    .C_EOL(2)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .enable(enable),
    .smpData(smpData),
    .smpValid(smpValid),
    .smpAck(smpAck),
    .busy(busy),
    .error(error),
    .txBusy(txBusy),
    .txSend(txSend),
    .txData(txData),
    .txErr(txErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART transmitter stand-in: accepts a byte when txSend is seen, stays busy
  // for 'latency' cycles, and can refuse one armed byte with an error pulse.
  initial begin
    txBusy = 1'b0;
    txErr  = 1'b0;
    forever begin
      @(negedge clk);
      txErr = 1'b0;
      if (rstb !== 1'b1) begin
        cnt    = 0;
        txBusy = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) txBusy = 1'b0;
      end else if (txSend === 1'b1) begin
        if (errArm && sentCount == errAt) begin
          txErr  = 1'b1;
          errArm = 0;
        end else begin
          rxQ.push_back(txData);
          txBusy = 1'b1;
          cnt    = latency;
        end
        sentCount++;
      end
    end
  end

  function automatic string hexLine(input logic [15:0] v);
    string s;
    s = $sformatf("%04h", v);
    s = s.toupper();
    return {s, "\r\n"};
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] v);
    int n;
    @(negedge clk);
    smpData  = v;
    smpValid = 1'b1;
    n = 0;
    while (smpAck !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", smpAck, 1);
    smpValid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input string exp);
    int n;
    int unsigned obs;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, busy, 0);
    check({tag, "_len"}, rxQ.size(), exp.len());
    for (int i = 0; i < exp.len(); i++) begin
      obs = (i < rxQ.size()) ? int'(rxQ[i]) : 32'hFFFF_FFFF;
      check($sformatf("%s_b%0d", tag, i), obs, exp[i]);
    end
    rxQ.delete();
  endtask

  initial begin
    logic [15:0] v;
    int  n;
    int  base;
    bit  ackEarly;

    rstb     = 1'b0;
    enable   = 1'b1;
    smpData  = '0;
    smpValid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   busy,   0);
    check("rst_ack",    smpAck, 0);
    check("rst_error",  error,  0);
    check("rst_txSend", txSend, 0);
    check("rst_txData", txData, 0);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // First frame with latency check: txSend on the second edge after capture.
    latency  = 3;
    smpData  = 16'h1A3F;
    smpValid = 1'b1;
    @(negedge clk);
    check("lat_ack",     smpAck, 1);
    check("lat_busy",    busy,   1);
    check("lat_send0",   txSend, 0);
    @(negedge clk);
    check("lat_send1",   txSend, 1);
    check("lat_data",    txData, 8'h31);
    smpValid = 1'b0;
    @(negedge clk);
    check("ack_clear",   smpAck, 0);
    checkOutput("f1A3F", hexLine(16'h1A3F));

    // Back-to-back: second sample must wait for the first frame to finish.
    latency = 2;
    applyStimulus(16'h0000);
    @(negedge clk);
    smpData  = 16'hFFFF;
    smpValid = 1'b1;
    ackEarly = 0;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      if (smpAck === 1'b1) ackEarly = 1;
      @(negedge clk);
      n++;
    end
    check("b2b_no_early_ack", ackEarly, 0);
    applyStimulus(16'hFFFF);
    checkOutput("b2b", {hexLine(16'h0000), hexLine(16'hFFFF)});

    // Error on the third byte: only the first two digits go out.
    latency = 2;
    errAt   = sentCount + 2;
    errArm  = 1;
    applyStimulus(16'hBEEF);
    n = 0;
    while (error !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("err_pulse",  error,  1);
    check("err_busy",   busy,   0);
    check("err_send",   txSend, 0);
    @(negedge clk);
    check("err_1cycle", error,  0);
    check("err_bytes",  rxQ.size(), 2);
    check("err_b0",     (rxQ.size() > 0) ? int'(rxQ[0]) : 32'hFFFF_FFFF, 8'h42);
    check("err_b1",     (rxQ.size() > 1) ? int'(rxQ[1]) : 32'hFFFF_FFFF, 8'h45);
    rxQ.delete();
    applyStimulus(16'hC0DE);
    checkOutput("after_err", hexLine(16'hC0DE));

    // Reset while the second byte is being presented.
    latency = 3;
    base = sentCount;
    applyStimulus(16'h5A5A);
    n = 0;
    while (!(txSend === 1'b1 && sentCount == base + 1) && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("rst_mid_reached", txSend, 1);
    rstb = 1'b0;
    #1;
    check("rstm_send", txSend, 0);
    check("rstm_busy", busy,   0);
    check("rstm_ack",  smpAck, 0);
    check("rstm_err",  error,  0);
    check("rstm_data", txData, 0);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    rxQ.delete();
    repeat (3) @(negedge clk);
    check("rstm_idle", busy, 0);
    applyStimulus(16'h1234);
    checkOutput("after_rst", hexLine(16'h1234));

    // enable low blocks capture; raising it captures on the next edge.
    @(negedge clk);
    enable   = 1'b0;
    smpData  = 16'h9A7C;
    smpValid = 1'b1;
    ackEarly = 0;
    repeat (100) begin
      @(negedge clk);
      if (smpAck === 1'b1) ackEarly = 1;
    end
    check("en_blocked", ackEarly, 0);
    enable = 1'b1;
    @(negedge clk);
    check("en_capture", smpAck, 1);
    smpValid = 1'b0;
    checkOutput("en_frame", hexLine(16'h9A7C));

    // Random samples; enable may drop mid-frame without truncating it.
    for (int k = 0; k < 20; k++) begin
      v       = 16'($urandom);
      latency = $urandom_range(1, 6);
      applyStimulus(v);
      enable = 1'($urandom_range(0, 1));
      checkOutput($sformatf("rnd%0d", k), hexLine(v));
      enable = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
